// File: rtl/game_ctrl.sv
// Game-state controller for the asteroid game: title/play/respawn/over FSM, lives, saturating score.
// Optional high-score register is built when GAME_CTRL_HISCORE_EN is defined.
module game_ctrl #(
    parameter int N_CH             = 3,
    parameter int LIVES            = 3,
    parameter int SCORE_W          = 8,
    parameter int INVULN_FRAMES    = 60,
    parameter int OVER_HOLD_FRAMES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixpulse,
    input  logic               move,
    input  logic [3:0]         btn,
    input  logic [N_CH-1:0]    hit,
    input  logic [N_CH-1:0]    score_inc,
    output logic [1:0]         state,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiscore,
    output logic               in_play,
    output logic               invuln,
    output logic               flash,
    output logic               life_lost
);

    typedef enum logic [1:0] {
        S_TITLE   = 2'd0,
        S_PLAY    = 2'd1,
        S_OVER    = 2'd2,
        S_RESPAWN = 2'd3
    } state_t;

    localparam int CW = $clog2(N_CH + 1);
    localparam int SW = SCORE_W + CW;
    localparam logic [SW-1:0] SCORE_MAX = {{CW{1'b0}}, {SCORE_W{1'b1}}};

    state_t               cur_state, nxt_state;
    logic [2:0]           lives_n;
    logic [SCORE_W-1:0]   score_n, score_sum;
    logic [7:0]           inv_cnt, inv_cnt_n, hold_cnt, hold_cnt_n;
    logic                 life_lost_n;
    logic [CW-1:0]        inc_cnt;
    logic [SW-1:0]        sum_wide;

    // Popcount of the score pulses, added with saturation at the top of the score range
    always_comb begin
        inc_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            inc_cnt = inc_cnt + CW'(score_inc[i]);
        end
        sum_wide  = SW'(score) + SW'(inc_cnt);
        score_sum = (sum_wide > SCORE_MAX) ? {SCORE_W{1'b1}} : sum_wide[SCORE_W-1:0];
    end

    always_comb begin
        nxt_state   = cur_state;
        lives_n     = lives;
        score_n     = score;
        inv_cnt_n   = inv_cnt;
        hold_cnt_n  = hold_cnt;
        life_lost_n = 1'b0;
        case (cur_state)
            S_TITLE: begin
                if (|btn) begin
                    nxt_state = S_PLAY;
                    lives_n   = 3'(LIVES);
                    score_n   = '0;
                end
            end
            S_PLAY: begin
                score_n = score_sum;
                if (|hit) begin
                    life_lost_n = 1'b1;
                    if (lives <= 3'd1) begin
                        nxt_state  = S_OVER;
                        lives_n    = 3'd0;
                        hold_cnt_n = 8'(OVER_HOLD_FRAMES);
                    end else begin
                        nxt_state = S_RESPAWN;
                        lives_n   = lives - 3'd1;
                        inv_cnt_n = 8'(INVULN_FRAMES);
                    end
                end
            end
            S_RESPAWN: begin
                score_n = score_sum;
                if (move) begin
                    if (inv_cnt <= 8'd1) begin
                        nxt_state = S_PLAY;
                        inv_cnt_n = 8'd0;
                    end else begin
                        inv_cnt_n = inv_cnt - 8'd1;
                    end
                end
            end
            S_OVER: begin
                // Restart needs the hold window to have fully expired and all four buttons pressed
                if (hold_cnt != 8'd0) begin
                    if (move) hold_cnt_n = hold_cnt - 8'd1;
                end else if (&btn) begin
                    nxt_state = S_PLAY;
                    lives_n   = 3'(LIVES);
                    score_n   = '0;
                end
            end
            default: nxt_state = S_TITLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_TITLE;
            lives     <= 3'(LIVES);
            score     <= '0;
            inv_cnt   <= 8'd0;
            hold_cnt  <= 8'd0;
            in_play   <= 1'b0;
            invuln    <= 1'b0;
            flash     <= 1'b1;
            life_lost <= 1'b0;
        end else begin
            // The pulse clears on the very next clk, independent of pixpulse
            life_lost <= pixpulse & life_lost_n;
            if (pixpulse) begin
                cur_state <= nxt_state;
                lives     <= lives_n;
                score     <= score_n;
                inv_cnt   <= inv_cnt_n;
                hold_cnt  <= hold_cnt_n;
                in_play   <= (nxt_state == S_PLAY) || (nxt_state == S_RESPAWN);
                invuln    <= (nxt_state == S_RESPAWN);
                flash     <= (nxt_state == S_RESPAWN) ? inv_cnt_n[2] : 1'b1;
            end
        end
    end

    assign state = cur_state;

`ifdef GAME_CTRL_HISCORE_EN
    // Captured on entry to OVER using the score of that same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hiscore <= '0;
        end else if (pixpulse && nxt_state == S_OVER && cur_state != S_OVER && score_n > hiscore) begin
            hiscore <= score_n;
        end
    end
`else
    assign hiscore = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl: start, scoring, respawn, game over, restart, reset.
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixpulse = 1'b0;
    logic       move = 1'b0;
    logic [3:0] btn = 4'd0;
    logic [2:0] hit = 3'd0;
    logic [2:0] score_inc = 3'd0;
    logic [1:0] state;
    logic [2:0] lives;
    logic [7:0] score;
    logic [7:0] hiscore;
    logic       in_play, invuln, flash, life_lost;

    int n_checks = 0;
    int n_fail   = 0;
    int ll_cnt   = 0;
    int ll_before;
    int exp_hi;

    game_ctrl dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .move(move), .btn(btn),
        .hit(hit), .score_inc(score_inc), .state(state), .lives(lives),
        .score(score), .hiscore(hiscore), .in_play(in_play), .invuln(invuln),
        .flash(flash), .life_lost(life_lost)
    );

    always #5 clk = ~clk;

    // Counts clk cycles on which life_lost is high
    always @(negedge clk) begin
        if (life_lost) ll_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One qualified cycle followed by three idle clocks with inputs cleared
    task automatic applyStimulus(input logic [3:0] b, input logic [2:0] h, input logic [2:0] s, input logic m);
        btn = b; hit = h; score_inc = s; move = m; pixpulse = 1'b1;
        @(posedge clk); #1;
        pixpulse = 1'b0; btn = 4'd0; hit = 3'd0; score_inc = 3'd0; move = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
`ifdef GAME_CTRL_HISCORE_EN
        exp_hi = 6;
`else
        exp_hi = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'(state), 0);
        checkOutput("reset_lives", 32'(lives), 3);
        checkOutput("reset_score", 32'(score), 0);
        checkOutput("reset_hiscore", 32'(hiscore), 0);
        checkOutput("reset_in_play", 32'(in_play), 0);
        checkOutput("reset_invuln", 32'(invuln), 0);
        checkOutput("reset_flash", 32'(flash), 1);
        checkOutput("reset_life_lost", 32'(life_lost), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Button without pixpulse is dropped
        btn = 4'b0001;
        @(posedge clk); #1;
        btn = 4'b0000;
        checkOutput("btn_dropped_state", 32'(state), 0);

        applyStimulus(4'b0001, 3'b000, 3'b000, 1'b0);
        checkOutput("start_state", 32'(state), 1);
        checkOutput("start_lives", 32'(lives), 3);
        checkOutput("start_score", 32'(score), 0);
        checkOutput("start_in_play", 32'(in_play), 1);

        applyStimulus(4'b0000, 3'b000, 3'b111, 1'b0);
        checkOutput("score_111", 32'(score), 3);
        applyStimulus(4'b0000, 3'b000, 3'b010, 1'b0);
        checkOutput("score_010", 32'(score), 4);

        score_inc = 3'b111;
        @(posedge clk); #1;
        score_inc = 3'b000;
        checkOutput("score_dropped", 32'(score), 4);

        ll_before = ll_cnt;
        applyStimulus(4'b0000, 3'b101, 3'b000, 1'b0);
        checkOutput("hit1_lives", 32'(lives), 2);
        checkOutput("hit1_state", 32'(state), 3);
        checkOutput("hit1_pulse", 32'(ll_cnt - ll_before), 1);
        checkOutput("hit1_invuln", 32'(invuln), 1);
        checkOutput("hit1_flash", 32'(flash), 1);

        applyStimulus(4'b0000, 3'b111, 3'b001, 1'b0);
        checkOutput("resp_hit_ignored_lives", 32'(lives), 2);
        checkOutput("resp_score", 32'(score), 5);

        for (int i = 1; i <= 59; i++) begin
            applyStimulus(4'b0000, 3'b111, 3'b000, 1'b1);
            if (i == 3) checkOutput("flash_cnt57", 32'(flash), 0);
        end
        checkOutput("resp59_state", 32'(state), 3);
        checkOutput("resp59_lives", 32'(lives), 2);
        checkOutput("resp59_flash", 32'(flash), 0);
        applyStimulus(4'b0000, 3'b000, 3'b000, 1'b1);
        checkOutput("resp60_state", 32'(state), 1);
        checkOutput("resp60_invuln", 32'(invuln), 0);
        checkOutput("resp60_flash", 32'(flash), 1);

        applyStimulus(4'b0000, 3'b010, 3'b000, 1'b0);
        checkOutput("hit2_lives", 32'(lives), 1);
        for (int i = 0; i < 60; i++) applyStimulus(4'b0000, 3'b000, 3'b000, 1'b1);
        checkOutput("hit2_back_state", 32'(state), 1);

        ll_before = ll_cnt;
        applyStimulus(4'b0000, 3'b001, 3'b001, 1'b0);
        checkOutput("fatal_score", 32'(score), 6);
        checkOutput("fatal_lives", 32'(lives), 0);
        checkOutput("fatal_state", 32'(state), 2);
        checkOutput("fatal_pulse", 32'(ll_cnt - ll_before), 1);
        checkOutput("fatal_in_play", 32'(in_play), 0);
        checkOutput("fatal_hiscore", 32'(hiscore), 32'(exp_hi));

        for (int i = 1; i <= 120; i++) begin
            applyStimulus(4'b1111, 3'b000, 3'b111, 1'b1);
            if (i == 1)   checkOutput("over1_state", 32'(state), 2);
            if (i == 119) checkOutput("over119_state", 32'(state), 2);
        end
        checkOutput("over120_state", 32'(state), 2);
        checkOutput("over_score_ignored", 32'(score), 6);
        applyStimulus(4'b1111, 3'b000, 3'b000, 1'b0);
        checkOutput("restart_state", 32'(state), 1);
        checkOutput("restart_lives", 32'(lives), 3);
        checkOutput("restart_score", 32'(score), 0);
        checkOutput("restart_hiscore", 32'(hiscore), 32'(exp_hi));

        for (int i = 0; i < 84; i++) applyStimulus(4'b0000, 3'b000, 3'b111, 1'b0);
        applyStimulus(4'b0000, 3'b000, 3'b010, 1'b0);
        applyStimulus(4'b0000, 3'b000, 3'b010, 1'b0);
        checkOutput("score_254", 32'(score), 254);
        applyStimulus(4'b0000, 3'b000, 3'b111, 1'b0);
        checkOutput("score_sat", 32'(score), 255);
        applyStimulus(4'b0000, 3'b000, 3'b111, 1'b0);
        checkOutput("score_sat_hold", 32'(score), 255);

        applyStimulus(4'b0000, 3'b001, 3'b000, 1'b0);
        for (int i = 0; i < 30; i++) applyStimulus(4'b0000, 3'b000, 3'b000, 1'b1);
        checkOutput("pre_rst_state", 32'(state), 3);
        rst = 1'b1;
        #1;
        checkOutput("midrst_state", 32'(state), 0);
        checkOutput("midrst_invuln", 32'(invuln), 0);
        checkOutput("midrst_lives", 32'(lives), 3);
        checkOutput("midrst_flash", 32'(flash), 1);
        checkOutput("midrst_score", 32'(score), 0);
        checkOutput("midrst_hiscore", 32'(hiscore), 0);
        checkOutput("midrst_in_play", 32'(in_play), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
